half16_align: RTL and testbench
===============================

HALF16_ALIGN -- requirements
Module: half16_align

Interface
REQ-001 Parameter: MAX_SHIFT, default 12, cap on serial right-shift steps applied to the smaller mantissa.
REQ-002 CLK  input  1  single clock; all state updates on rising edge.
REQ-003 RST_N  input  1  asynchronous, active-low reset.
REQ-004 IN_VALID  input  1  operand pair valid.
REQ-005 IN_READY  output  1  block can accept an operand pair.
REQ-006 IN_A  input  16  FP16 operand A {sign, exp[4:0], mant[9:0]}.
REQ-007 IN_B  input  16  FP16 operand B, same format.
REQ-008 OUT_VALID  output  1  aligned result valid.
REQ-009 OUT_READY  input  1  downstream sum stage accepts result.
REQ-010 SIGN_A  output  1  sign of larger-magnitude operand.
REQ-011 SIGN_B  output  1  sign of smaller-magnitude operand.
REQ-012 OUT_EXP_HALF  output  5  common exponent (larger operand's effective exponent).
REQ-013 OUT_MANT_A_HALF  output  11  larger operand mantissa with hidden bit.
REQ-014 OUT_MANT_B_HALF  output  11  smaller operand mantissa, right-shifted to align.
REQ-015 STICKY_BIT  output  1  OR of all bits shifted out of the smaller mantissa.
REQ-016 OUT_SPECIAL  output  1  either operand has exp field 31 (Inf/NaN).

Function
REQ-017 Unpack: hidden bit = (exp != 0); effective exponent = 1 when exp == 0, else exp; 11-bit mantissa = {hidden, mant}.
REQ-018 Ordering: compare {eff_exp, mant11}; A is larger when A >= B (tie keeps A in slot A); otherwise swap operands and signs.
REQ-019 Shift distance d = eff_exp_large - eff_exp_small, range 0..29; steps executed = min(d, MAX_SHIFT).
REQ-020 FSM states: IDLE, SHIFT, DONE.
REQ-021 IN_READY = 1 only in IDLE; handshake fires when IN_VALID & IN_READY on a rising edge.
REQ-022 IDLE on handshake: register unpacked/ordered operands, clear sticky, load step counter; go to SHIFT if steps > 0 and not special, else DONE.
REQ-023 SHIFT: each cycle shift small mantissa right by 1, sticky |= bit shifted out, decrement counter; go to DONE when counter reaches 0 on that edge.
REQ-024 When d > MAX_SHIFT, after the last step sticky additionally ORs in any remaining mantissa bits and the mantissa is forced to 0.
REQ-025 Special: any exp == 31 skips SHIFT; operands pass ordered but unshifted, STICKY_BIT = 0, OUT_SPECIAL = 1.
REQ-026 DONE: OUT_VALID = 1; all outputs held stable until OUT_READY = 1; on OUT_VALID & OUT_READY return to IDLE.
REQ-027 Latency: OUT_VALID asserts 1 + steps cycles after the accepting edge (1 cycle for d = 0 or special).
REQ-028 No new operand accepted in SHIFT or DONE; IN_A/IN_B changes there have no effect.
REQ-029 Both operands zero: EXP = 1, mantissas 0, sticky 0, latency 1.
REQ-030 Throughput: at most one operand pair in flight; next accept no earlier than the cycle after the output handshake.

Reset
REQ-031 RST_N low asynchronously forces IDLE, OUT_VALID = 0, all data outputs and counter = 0, sticky = 0, OUT_SPECIAL = 0.
REQ-032 IN_READY = 1 while and after reset; reset mid-SHIFT or mid-DONE discards the in-flight pair with no output.

Verification
REQ-033 A=0x3C00, B=0x3800 -> SIGN_A=0, EXP=15, MANT_A=0x400, MANT_B=0x200, STICKY=0, OUT_VALID 2 cycles after accept.
REQ-034 A=0xB800, B=0x3C00 -> swap: SIGN_A=0, SIGN_B=1, EXP=15, MANT_A=0x400, MANT_B=0x200.
REQ-035 A=0x4000, B=0x3401 -> d=3: EXP=16, MANT_B=0x080, STICKY=1, latency 4.
REQ-036 A=0x7BFF, B=0x0001 -> d=29 capped at 12: EXP=30, MANT_A=0x7FF, MANT_B=0, STICKY=1, latency 13; A=0x7C00 with any B -> OUT_SPECIAL=1, latency 1.
REQ-037 OUT_READY held low 5 cycles in DONE -> outputs unchanged, IN_READY=0, concurrent IN_VALID ignored; accept resumes after the output handshake.
REQ-038 RST_N pulsed low during SHIFT of REQ-036 case -> OUT_VALID=0 and IN_READY=1 immediately; the discarded pair never appears at the output.

Source files
------------

// File: rtl/half16_align.sv
// half16_align: FP16 operand alignment ahead of a mantissa adder.
// It unpacks both operands and orders them by magnitude. The smaller mantissa
// is shifted right one bit per cycle, and the sticky bit collects every bit
// that falls off the end. One operand pair is in flight at a time.
module half16_align #(
   parameter int MAX_SHIFT = 12
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [15:0] in_a,
   input  logic [15:0] in_b,
   output logic        out_valid,
   input  logic        out_ready,
   output logic        sign_a,
   output logic        sign_b,
   output logic [4:0]  out_exp_half,
   output logic [10:0] out_mant_a_half,
   output logic [10:0] out_mant_b_half,
   output logic        sticky_bit,
   output logic        out_special
);

   // Exponent differences never exceed 29, so a larger cap behaves as "no cap".
   localparam int          LP_CAP_INT = (MAX_SHIFT > 29) ? 29 : ((MAX_SHIFT < 0) ? 0 : MAX_SHIFT);
   localparam logic [4:0]  LP_CAP     = 5'(LP_CAP_INT);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_DONE  = 2'd2
   } state_t;

   state_t        r_state;
   logic          r_in_ready;
   logic          r_out_valid;
   logic          r_sign_a;
   logic          r_sign_b;
   logic [4:0]    r_exp;
   logic [10:0]   r_mant_a;
   logic [10:0]   r_mant_b;
   logic          r_sticky;
   logic          r_special;
   logic [4:0]    r_cnt;
   logic          r_trunc;

   logic          w_hid_a, w_hid_b;
   logic [4:0]    w_eexp_a, w_eexp_b;
   logic [10:0]   w_man_a, w_man_b;
   logic          w_a_ge;
   logic          w_sign_l, w_sign_s;
   logic [4:0]    w_eexp_l, w_eexp_s;
   logic [10:0]   w_man_l, w_man_s;
   logic [4:0]    w_dist;
   logic [4:0]    w_steps;
   logic          w_trunc;
   logic          w_special;
   logic          w_accept;
   logic          w_release;
   logic [10:0]   w_shift_mant;
   logic          w_shift_out;
   logic          w_last_step;

   // Number of serial steps actually executed for a given exponent difference.
   function automatic logic [4:0] clamp_steps(input logic [4:0] d);
      return (d > LP_CAP) ? LP_CAP : d;
   endfunction

   // Sticky update for one shift step; on the final step of a capped shift the
   // bits still left in the mantissa are folded in as well.
   function automatic logic next_sticky(input logic cur, input logic out_bit,
                                        input logic [10:0] rest, input logic flush);
      return cur | out_bit | (flush & (|rest));
   endfunction

   // Unpack both operands, order them by magnitude and derive the shift plan.
   always_comb begin
      w_hid_a   = |in_a[14:10];
      w_hid_b   = |in_b[14:10];
      w_eexp_a  = w_hid_a ? in_a[14:10] : 5'd1;
      w_eexp_b  = w_hid_b ? in_b[14:10] : 5'd1;
      w_man_a   = {w_hid_a, in_a[9:0]};
      w_man_b   = {w_hid_b, in_b[9:0]};
      w_a_ge    = {w_eexp_a, w_man_a} >= {w_eexp_b, w_man_b};
      w_sign_l  = w_a_ge ? in_a[15] : in_b[15];
      w_sign_s  = w_a_ge ? in_b[15] : in_a[15];
      w_eexp_l  = w_a_ge ? w_eexp_a : w_eexp_b;
      w_eexp_s  = w_a_ge ? w_eexp_b : w_eexp_a;
      w_man_l   = w_a_ge ? w_man_a : w_man_b;
      w_man_s   = w_a_ge ? w_man_b : w_man_a;
      w_dist    = w_eexp_l - w_eexp_s;
      w_steps   = clamp_steps(w_dist);
      w_trunc   = (w_dist > LP_CAP);
      w_special = (&in_a[14:10]) | (&in_b[14:10]);
   end

   // Handshake qualifiers and the single-step shift datapath.
   always_comb begin
      w_accept     = in_valid & r_in_ready;
      w_release    = r_out_valid & out_ready;
      w_shift_mant = r_mant_b >> 1;
      w_shift_out  = r_mant_b[0];
      w_last_step  = (r_cnt == 5'd1);
   end

   // Control FSM with all result registers; outputs come straight from flops.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= ST_IDLE;
         r_in_ready  <= 1'b1;
         r_out_valid <= 1'b0;
         r_sign_a    <= 1'b0;
         r_sign_b    <= 1'b0;
         r_exp       <= 5'd0;
         r_mant_a    <= 11'd0;
         r_mant_b    <= 11'd0;
         r_sticky    <= 1'b0;
         r_special   <= 1'b0;
         r_cnt       <= 5'd0;
         r_trunc     <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_accept) begin
                  r_in_ready <= 1'b0;
                  r_sign_a   <= w_sign_l;
                  r_sign_b   <= w_sign_s;
                  r_exp      <= w_eexp_l;
                  r_mant_a   <= w_man_l;
                  r_mant_b   <= w_man_s;
                  r_sticky   <= 1'b0;
                  r_special  <= w_special;
                  r_trunc    <= w_trunc & ~w_special;
                  if (!w_special && (w_steps != 5'd0)) begin
                     r_cnt   <= w_steps;
                     r_state <= ST_SHIFT;
                  end else begin
                     r_cnt       <= 5'd0;
                     r_out_valid <= 1'b1;
                     r_state     <= ST_DONE;
                  end
               end
            end
            ST_SHIFT: begin
               r_cnt    <= r_cnt - 5'd1;
               r_sticky <= next_sticky(r_sticky, w_shift_out, w_shift_mant,
                                       w_last_step & r_trunc);
               if (w_last_step && r_trunc) begin
                  r_mant_b <= 11'd0;
               end else begin
                  r_mant_b <= w_shift_mant;
               end
               if (w_last_step) begin
                  r_out_valid <= 1'b1;
                  r_state     <= ST_DONE;
               end
            end
            ST_DONE: begin
               if (w_release) begin
                  r_out_valid <= 1'b0;
                  r_in_ready  <= 1'b1;
                  r_state     <= ST_IDLE;
               end
            end
            default: begin
               r_out_valid <= 1'b0;
               r_in_ready  <= 1'b1;
               r_state     <= ST_IDLE;
            end
         endcase
      end
   end

   assign in_ready        = r_in_ready;
   assign out_valid       = r_out_valid;
   assign sign_a          = r_sign_a;
   assign sign_b          = r_sign_b;
   assign out_exp_half    = r_exp;
   assign out_mant_a_half = r_mant_a;
   assign out_mant_b_half = r_mant_b;
   assign sticky_bit      = r_sticky;
   assign out_special     = r_special;

endmodule

// File: tb/tb_half16_align.sv
// Directed testbench for half16_align with hand-computed expected results.
module tb_half16_align;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] in_a;
   logic [15:0] in_b;
   logic        out_valid;
   logic        out_ready;
   logic        sign_a;
   logic        sign_b;
   logic [4:0]  out_exp_half;
   logic [10:0] out_mant_a_half;
   logic [10:0] out_mant_b_half;
   logic        sticky_bit;
   logic        out_special;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   half16_align #(.MAX_SHIFT(12)) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .in_valid        (in_valid),
      .in_ready        (in_ready),
      .in_a            (in_a),
      .in_b            (in_b),
      .out_valid       (out_valid),
      .out_ready       (out_ready),
      .sign_a          (sign_a),
      .sign_b          (sign_b),
      .out_exp_half    (out_exp_half),
      .out_mant_a_half (out_mant_a_half),
      .out_mant_b_half (out_mant_b_half),
      .sticky_bit      (sticky_bit),
      .out_special     (out_special)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_fields(input string tag, input logic sa, input logic sb,
                             input logic [4:0] e, input logic [10:0] ma,
                             input logic [10:0] mb, input logic st, input logic sp);
      chk({tag, "_sign_a"}, 32'(sign_a), 32'(sa));
      chk({tag, "_sign_b"}, 32'(sign_b), 32'(sb));
      chk({tag, "_exp"},    32'(out_exp_half), 32'(e));
      chk({tag, "_mant_a"}, 32'(out_mant_a_half), 32'(ma));
      chk({tag, "_mant_b"}, 32'(out_mant_b_half), 32'(mb));
      chk({tag, "_sticky"}, 32'(sticky_bit), 32'(st));
      chk({tag, "_special"}, 32'(out_special), 32'(sp));
   endtask

   // Launch one pair; returns the observed latency (cycles after the accepting edge).
   task automatic launch(input logic [15:0] a, input logic [15:0] b, output int n);
      @(negedge clk);
      in_a      = a;
      in_b      = b;
      in_valid  = 1'b1;
      out_ready = 1'b0;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      n = 1;
      while (!out_valid && n < 40) begin
         @(negedge clk);
         n++;
      end
   endtask

   task automatic run_op(input logic [15:0] a, input logic [15:0] b,
                         input logic sa, input logic sb, input logic [4:0] e,
                         input logic [10:0] ma, input logic [10:0] mb,
                         input logic st, input logic sp, input int lat, input string tag);
      int n;
      chk({tag, "_ready_before"}, 32'(in_ready), 32'd1);
      launch(a, b, n);
      chk({tag, "_latency"}, 32'(n), 32'(lat));
      chk({tag, "_valid"}, 32'(out_valid), 32'd1);
      chk_fields(tag, sa, sb, e, ma, mb, st, sp);
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      chk({tag, "_valid_after"}, 32'(out_valid), 32'd0);
      chk({tag, "_ready_after"}, 32'(in_ready), 32'd1);
   endtask

   initial begin
      int  n;
      logic seen;
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_a      = 16'h0000;
      in_b      = 16'h0000;
      out_ready = 1'b0;
      #12;
      chk("rst_in_ready", 32'(in_ready), 32'd1);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk_fields("rst", 1'b0, 1'b0, 5'd0, 11'h000, 11'h000, 1'b0, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      run_op(16'h3C00, 16'h3800, 1'b0, 1'b0, 5'd15, 11'h400, 11'h200, 1'b0, 1'b0, 2,  "d1");
      run_op(16'hB800, 16'h3C00, 1'b0, 1'b1, 5'd15, 11'h400, 11'h200, 1'b0, 1'b0, 2,  "swap");
      run_op(16'h4000, 16'h3401, 1'b0, 1'b0, 5'd16, 11'h400, 11'h080, 1'b1, 1'b0, 4,  "d3");
      run_op(16'h7BFF, 16'h0001, 1'b0, 1'b0, 5'd30, 11'h7FF, 11'h000, 1'b1, 1'b0, 13, "cap29");
      run_op(16'h7C00, 16'h3C00, 1'b0, 1'b0, 5'd31, 11'h400, 11'h400, 1'b0, 1'b1, 1,  "inf");
      run_op(16'h3C00, 16'h7E00, 1'b0, 1'b0, 5'd31, 11'h600, 11'h400, 1'b0, 1'b1, 1,  "nan_swap");
      run_op(16'h0000, 16'h0000, 1'b0, 1'b0, 5'd1,  11'h000, 11'h000, 1'b0, 1'b0, 1,  "zero");
      run_op(16'h3C00, 16'hBC00, 1'b0, 1'b1, 5'd15, 11'h400, 11'h400, 1'b0, 1'b0, 1,  "tie");
      run_op(16'h0400, 16'h03FF, 1'b0, 1'b0, 5'd1,  11'h400, 11'h3FF, 1'b0, 1'b0, 1,  "denorm");
      run_op(16'h4000, 16'h1800, 1'b0, 1'b0, 5'd16, 11'h400, 11'h001, 1'b0, 1'b0, 11, "d10");
      run_op(16'h4000, 16'h1001, 1'b0, 1'b0, 5'd16, 11'h400, 11'h000, 1'b1, 1'b0, 13, "d12");
      run_op(16'hC000, 16'h8001, 1'b1, 1'b1, 5'd16, 11'h400, 11'h000, 1'b1, 1'b0, 13, "neg_cap");

      // Backpressure: result must hold and new operands must be ignored.
      launch(16'h4000, 16'h3401, n);
      chk("hold_latency", 32'(n), 32'd4);
      for (int i = 0; i < 5; i++) begin
         in_valid = 1'b1;
         in_a     = 16'h3C00 + 16'(i);
         in_b     = 16'h7BFF - 16'(i);
         @(negedge clk);
         chk("hold_valid", 32'(out_valid), 32'd1);
         chk("hold_in_ready", 32'(in_ready), 32'd0);
         chk_fields("hold", 1'b0, 1'b0, 5'd16, 11'h400, 11'h080, 1'b1, 1'b0);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      chk("hold_release_valid", 32'(out_valid), 32'd0);
      chk("hold_release_ready", 32'(in_ready), 32'd1);
      run_op(16'hB800, 16'h3C00, 1'b0, 1'b1, 5'd15, 11'h400, 11'h200, 1'b0, 1'b0, 2, "resume");

      // Reset in the middle of a long shift discards the pair.
      @(negedge clk);
      in_a     = 16'h7BFF;
      in_b     = 16'h0001;
      in_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      chk("midrst_valid", 32'(out_valid), 32'd0);
      chk("midrst_ready", 32'(in_ready), 32'd1);
      chk("midrst_exp", 32'(out_exp_half), 32'd0);
      chk("midrst_mant_a", 32'(out_mant_a_half), 32'd0);
      chk("midrst_sticky", 32'(sticky_bit), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      seen  = 1'b0;
      for (int i = 0; i < 16; i++) begin
         @(negedge clk);
         if (out_valid) seen = 1'b1;
      end
      chk("midrst_no_output", 32'(seen), 32'd0);
      run_op(16'h3C00, 16'h3800, 1'b0, 1'b0, 5'd15, 11'h400, 11'h200, 1'b0, 1'b0, 2, "post_rst");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete, observed timeout expected finish");
      $fatal(1, "watchdog expired");
   end

endmodule
